// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the stage-3 data-memory path.
//   DATA_WIDTH          - width of a data-memory word
//   DMEM_ADDRESS_LENGTH - SRAM word-address width
//   sb_entry_t          - one buffered store {addr, data}
//   sb_state_t          - store-buffer control state (RUN / FLUSH)
package pipeline_pkg;

  localparam int DATA_WIDTH          = 64;
  localparam int DMEM_ADDRESS_LENGTH = 16;

  typedef struct packed {
    logic [DMEM_ADDRESS_LENGTH-1:0] addr;
    logic [DATA_WIDTH-1:0]          data;
  } sb_entry_t;

  typedef enum logic {
    SB_RUN   = 1'b0,
    SB_FLUSH = 1'b1
  } sb_state_t;

endpackage

// File: rtl/sb_fifo.sv
// Store-buffer FIFO: entry storage, read/write pointers, occupancy count,
// full/empty flags and an associative lookup over all valid entries.
// Ports:
//   clk, rst          clock, asynchronous active-low reset (pointers/count only)
//   push, push_entry  enqueue one entry at the clock edge
//   pop               dequeue the head at the clock edge
//   head              oldest entry (meaningless when empty)
//   full, empty       occupancy flags
//   lookup_addr       address compared against every valid entry
//   match_any         at least one valid entry holds lookup_addr
//   match_data        data of the youngest matching entry
module sb_fifo
  import pipeline_pkg::*;
#(
  parameter int SB_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  sb_entry_t                      push_entry,
  input  logic                           pop,
  output sb_entry_t                      head,
  output logic                           full,
  output logic                           empty,
  input  logic [DMEM_ADDRESS_LENGTH-1:0] lookup_addr,
  output logic                           match_any,
  output logic [DATA_WIDTH-1:0]          match_data
);

  localparam int PW = $clog2(SB_DEPTH);
  localparam int CW = $clog2(SB_DEPTH + 1);

  sb_entry_t         mem [SB_DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count;

  assign full  = (count == CW'(SB_DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // Pointers wrap naturally because SB_DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  // Walk from oldest to youngest so the last hit left standing is the youngest.
  always_comb begin
    logic [PW-1:0] idx;
    idx        = '0;
    match_any  = 1'b0;
    match_data = '0;
    for (int k = 0; k < SB_DEPTH; k++) begin
      idx = rd_ptr + PW'(k);
      if ((CW'(k) < count) && (mem[idx].addr == lookup_addr)) begin
        match_any  = 1'b1;
        match_data = mem[idx].data;
      end
    end
  end

endmodule

// File: rtl/dmem_store_buffer.sv
// Data-memory store buffer between the stage-3 dmem port and a single-port
// synchronous SRAM. Stores are posted into sb_fifo and written back on
// cycles the request stream leaves the SRAM port free; loads own the port
// and return data one cycle after acceptance. A FLUSH state drains the
// buffer completely while holding off all new memory ops.
// Configuration macro: STORE_FWD_EN
//   defined   - a load hitting a buffered store is served from the buffer
//   undefined - a load hitting a buffered store stalls until it drains
// Ports:
//   clk, rst                   clock, asynchronous active-low reset
//   mem_enable, store_enable   op request (store_enable ignored when idle)
//   dmem_address, dmem_dataIn  word address (low bits used), store data
//   dmem_dataOut               load data, valid the cycle after acceptance
//   stall                      current op not accepted this cycle
//   flush_req, flush_done      drain request (level) / completion pulse
//   sram_en, sram_we, sram_addr, sram_wdata, sram_rdata   SRAM port
module dmem_store_buffer #(
  parameter int DATA_WIDTH          = pipeline_pkg::DATA_WIDTH,
  parameter int DMEM_ADDRESS_LENGTH = pipeline_pkg::DMEM_ADDRESS_LENGTH,
  parameter int SB_DEPTH            = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           mem_enable,
  input  logic                           store_enable,
  input  logic [31:0]                    dmem_address,
  input  logic [DATA_WIDTH-1:0]          dmem_dataIn,
  output logic [DATA_WIDTH-1:0]          dmem_dataOut,
  output logic                           stall,
  input  logic                           flush_req,
  output logic                           flush_done,
  output logic                           sram_en,
  output logic                           sram_we,
  output logic [DMEM_ADDRESS_LENGTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0]          sram_wdata,
  input  logic [DATA_WIDTH-1:0]          sram_rdata
);

  import pipeline_pkg::*;

  logic [DMEM_ADDRESS_LENGTH-1:0] op_addr;
  logic                           unused_addr_hi;
  logic                           is_store, is_load, in_flush;
  logic                           st_acc, ld_sram, ld_fwd, drain;
  logic                           fifo_full, fifo_empty, match_any;
  logic [DATA_WIDTH-1:0]          match_data;
  sb_entry_t                      push_entry, head;
  sb_state_t                      state_q, state_d;
  logic                           ld_vld_p1;
  logic [DATA_WIDTH-1:0]          ld_data_p1;

  assign op_addr        = dmem_address[DMEM_ADDRESS_LENGTH-1:0];
  assign unused_addr_hi = ^dmem_address[31:DMEM_ADDRESS_LENGTH];

  assign is_store = mem_enable & store_enable;
  assign is_load  = mem_enable & ~store_enable;

  // An accepted store takes the port slot for the cycle, so back-to-back
  // stores accumulate in the buffer; stalled or forwarded ops leave it free.
  assign st_acc = is_store & ~in_flush & ~fifo_full;
`ifdef STORE_FWD_EN
  assign ld_fwd  = is_load & ~in_flush & match_any;
  assign ld_sram = is_load & ~in_flush & ~match_any;
  assign stall   = (is_store & (in_flush | fifo_full)) | (is_load & in_flush);
`else
  assign ld_fwd  = 1'b0;
  assign ld_sram = is_load & ~in_flush & ~match_any;
  assign stall   = (is_store & (in_flush | fifo_full)) |
                   (is_load & (in_flush | match_any));
`endif
  assign drain = ~st_acc & ~ld_sram & ~fifo_empty;

  always_comb begin
    push_entry      = '0;
    push_entry.addr = op_addr;
    push_entry.data = dmem_dataIn;
  end

  sb_fifo #(
    .SB_DEPTH (SB_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push        (st_acc),
    .push_entry  (push_entry),
    .pop         (drain),
    .head        (head),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .lookup_addr (op_addr),
    .match_any   (match_any),
    .match_data  (match_data)
  );

  assign sram_en = ld_sram | drain;
  assign sram_we = drain;

  always_comb begin
    sram_addr  = '0;
    sram_wdata = '0;
    if (ld_sram) begin
      sram_addr = op_addr;
    end else if (drain) begin
      sram_addr  = head.addr;
      sram_wdata = head.data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= SB_RUN;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      SB_RUN:   if (flush_req)  state_d = SB_FLUSH;
      SB_FLUSH: if (fifo_empty) state_d = SB_RUN;
      default:  state_d = SB_RUN;
    endcase
  end

  always_comb begin
    in_flush   = (state_q == SB_FLUSH);
    flush_done = in_flush & fifo_empty;
  end

  // ---- p1: load return (SRAM read data or registered forward data) ----
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ld_vld_p1  <= 1'b0;
      ld_data_p1 <= '0;
    end else begin
      ld_vld_p1 <= ld_sram;
      if (ld_fwd)         ld_data_p1 <= match_data;
      else if (ld_vld_p1) ld_data_p1 <= sram_rdata;
    end
  end

  assign dmem_dataOut = ld_vld_p1 ? sram_rdata : ld_data_p1;

endmodule

// File: tb/tb_dmem_store_buffer.sv
module tb_dmem_store_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        mem_enable, store_enable, flush_req;
  logic [31:0] dmem_address;
  logic [63:0] dmem_dataIn, dmem_dataOut;
  logic        stall, flush_done, sram_en, sram_we;
  logic [15:0] sram_addr;
  logic [63:0] sram_wdata;
  logic [63:0] sram_rdata = '0;

  int vectors     = 0;
  int miscompares = 0;

  logic [15:0] wr_addr_q [$];
  logic [63:0] wr_data_q [$];
  logic [63:0] ld_q      [$];

  logic [63:0] sram_mem [0:1023];

  always #5 clk = ~clk;

  dmem_store_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .mem_enable   (mem_enable),
    .store_enable (store_enable),
    .dmem_address (dmem_address),
    .dmem_dataIn  (dmem_dataIn),
    .dmem_dataOut (dmem_dataOut),
    .stall        (stall),
    .flush_req    (flush_req),
    .flush_done   (flush_done),
    .sram_en      (sram_en),
    .sram_we      (sram_we),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata)
  );

  // Synchronous SRAM model with registered read data.
  always @(posedge clk) begin
    if (sram_en) begin
      if (sram_we) sram_mem[sram_addr[9:0]] <= sram_wdata;
      else         sram_rdata <= sram_mem[sram_addr[9:0]];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    mem_enable   = 1'b0;
    store_enable = 1'b0;
  endtask

  task automatic st(input logic [31:0] a, input logic [63:0] d, input bit expect_write);
    mem_enable   = 1'b1;
    store_enable = 1'b1;
    dmem_address = a;
    dmem_dataIn  = d;
    if (expect_write) begin
      wr_addr_q.push_back(a[15:0]);
      wr_data_q.push_back(d);
    end
  endtask

  task automatic ld(input logic [31:0] a, input logic [63:0] exp_data);
    mem_enable   = 1'b1;
    store_enable = 1'b0;
    dmem_address = a;
    ld_q.push_back(exp_data);
  endtask

  // One clock: check combinational outputs, scoreboard any SRAM write,
  // then check returned load data one cycle after an accepted load.
  task automatic cyc(input logic exp_stall, input logic exp_en, input logic exp_fd);
    logic ld_taken;
    logic stall_s;
    #1;
    chk("stall", stall, exp_stall);
    chk("sram_en", sram_en, exp_en);
    chk("flush_done", flush_done, exp_fd);
    stall_s  = stall;
    ld_taken = mem_enable && !store_enable && !stall;
    if (sram_en && sram_we) begin
      if (wr_addr_q.size() == 0) begin
        chk("unexpected_write", sram_we, 1'b0);
      end else begin
        chk("wr_addr", sram_addr, wr_addr_q.pop_front());
        chk("wr_data", sram_wdata, wr_data_q.pop_front());
      end
    end
    @(posedge clk);
    @(negedge clk);
    if (ld_taken) begin
      if (ld_q.size() == 0) chk("unexpected_load", stall_s, 1'b1);
      else                  chk("ld_data", dmem_dataOut, ld_q.pop_front());
    end
  endtask

  initial begin
    rst = 1'b0;
    flush_req = 1'b0;
    dmem_address = '0;
    dmem_dataIn = '0;
    idle();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_stall", stall, 0);
    chk("rst_sram_en", sram_en, 0);
    chk("rst_flush_done", flush_done, 0);
    chk("rst_dout", dmem_dataOut, 0);
    @(negedge clk);
    rst = 1'b1;

    // single store, drains on the first idle cycle
    st(32'h10, 64'hAA, 1); cyc(0, 0, 0);
    idle();                cyc(0, 1, 0);
    cyc(0, 0, 0);

    // five back-to-back stores: fifth stalls while the head drains
    for (int i = 0; i < 4; i++) begin
      st(32'h100 + i, 64'hD0 + i, 1); cyc(0, 0, 0);
    end
    st(32'h104, 64'hD4, 1); cyc(1, 1, 0);
    cyc(0, 0, 0);
    idle();
    repeat (4) cyc(0, 1, 0);
    cyc(0, 0, 0);

    // store then immediate load of the same address
    st(32'h20, 64'h55, 1); cyc(0, 0, 0);
    ld(32'h20, 64'h55);
`ifdef STORE_FWD_EN
    cyc(0, 1, 0);
`else
    cyc(1, 1, 0);
    cyc(0, 1, 0);
`endif
    idle(); cyc(0, 0, 0);

    // two stores to one address: the younger data must win
    st(32'h30, 64'h1, 1); cyc(0, 0, 0);
    st(32'h30, 64'h2, 1); cyc(0, 0, 0);
    ld(32'h30, 64'h2);
`ifdef STORE_FWD_EN
    cyc(0, 1, 0);
    idle(); cyc(0, 1, 0);
`else
    cyc(1, 1, 0);
    cyc(1, 1, 0);
    cyc(0, 1, 0);
    idle();
`endif
    cyc(0, 0, 0);
    chk("ld_hold", dmem_dataOut, 64'h2);

    // plain loads with no buffered match
    ld(32'h10, 64'hAA);  cyc(0, 1, 0);
    ld(32'h100, 64'hD0); cyc(0, 1, 0);
    idle(); cyc(0, 0, 0);
    chk("ld_hold2", dmem_dataOut, 64'hD0);

    // flush with three entries; a load waits out the FLUSH state
    for (int i = 0; i < 3; i++) begin
      st(32'h40 + i, 64'h1 + i, 1); cyc(0, 0, 0);
    end
    idle(); flush_req = 1'b1; cyc(0, 1, 0);
    flush_req = 1'b0;
    ld(32'h10, 64'hAA);
    cyc(1, 1, 0);
    cyc(1, 1, 0);
    cyc(1, 0, 1);
    cyc(0, 1, 0);
    idle(); cyc(0, 0, 0);

    // flush with an empty buffer pulses done the following cycle
    flush_req = 1'b1; cyc(0, 0, 0);
    flush_req = 1'b0; cyc(0, 0, 1);
    cyc(0, 0, 0);

    // reset while holding three entries: they must never reach the SRAM
    for (int i = 0; i < 3; i++) begin
      st(32'h50 + i, 64'hE0 + i, 0); cyc(0, 0, 0);
    end
    idle();
    rst = 1'b0;
    #1;
    chk("mid_rst_sram_en", sram_en, 0);
    chk("mid_rst_sram_we", sram_we, 0);
    chk("mid_rst_sram_addr", sram_addr, 0);
    chk("mid_rst_sram_wdata", sram_wdata, 0);
    chk("mid_rst_stall", stall, 0);
    chk("mid_rst_dout", dmem_dataOut, 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (3) cyc(0, 0, 0);

    chk("wr_q_drained", wr_addr_q.size(), 0);
    chk("ld_q_drained", ld_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
